// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder
//   Frames signed recorder samples into FRAME_LEN-point frames and streams
//   them to the FFT core over AXI-Stream. Two ping-pong buffers absorb FFT
//   back-pressure. A flush pulse zero-pads the partial tail frame.
//
//   clk_in           system clock
//   rst_in_n         asynchronous reset, active-low (released synchronously)
//   sample_valid_in  one-cycle strobe qualifying sample_in
//   sample_in        signed audio sample
//   flush_in         one-cycle pulse: zero-pad the current partial frame
//   m_axis_tdata     {16'h0000, sample, 8'h00}: real in [15:0], imag = 0
//   m_axis_tvalid    beat valid
//   m_axis_tready    FFT core ready
//   m_axis_tlast     high on the last beat of each frame
//   frame_count_out  frames fully handed to the FFT (wraps)
//   overflow_out     sticky: a sample was dropped with both buffers full
//   busy_out         any buffer full, padding, or streaming in progress
module fft_frame_feeder #(
    parameter int unsigned FRAME_LEN = 2048,
    parameter int unsigned SAMPLE_W  = 8
) (
    input  logic                clk_in,
    input  logic                rst_in_n,
    input  logic                sample_valid_in,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                flush_in,
    output logic [31:0]         m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic [15:0]         frame_count_out,
    output logic                overflow_out,
    output logic                busy_out
);

    localparam int unsigned   AW       = $clog2(FRAME_LEN);
    localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

    typedef enum logic       {W_FILL, W_PAD} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_PREFETCH, R_STREAM} rstate_t;

    wstate_t             wstate, wstate_d;
    rstate_t             rstate, rstate_d;
    logic [1:0]          rst_sync;
    logic                rst_n;
    logic [AW-1:0]       wr_ptr, rd_ptr, rd_addr;
    logic                wr_sel, rd_sel;
    logic [1:0]          full, full_d;
    logic                we, drop, wr_done, re, hs, last_hs;
    logic [SAMPLE_W-1:0] wdata, rd_q;
    logic                tvalid, tlast, overflow, busy;
    logic [15:0]         frame_count;
    logic [SAMPLE_W-1:0] mem [2*FRAME_LEN];

    // Reset asserts immediately and releases two clocks later.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) rst_sync <= '0;
        else           rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    // State registers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wstate <= W_FILL;
            rstate <= R_IDLE;
        end else begin
            wstate <= wstate_d;
            rstate <= rstate_d;
        end
    end

    // Next-state logic
    always_comb begin
        wstate_d = wstate;
        unique case (wstate)
            // Pad only if the frame is still partial after this cycle's write.
            W_FILL: if (flush_in && !wr_done && (wr_ptr != '0 || we)) wstate_d = W_PAD;
            W_PAD:  if (wr_done) wstate_d = W_FILL;
            default: wstate_d = W_FILL;
        endcase

        rstate_d = rstate;
        unique case (rstate)
            R_IDLE:     if (full[rd_sel]) rstate_d = R_PREFETCH;
            R_PREFETCH: rstate_d = R_STREAM;
            R_STREAM:   if (last_hs) rstate_d = full[~rd_sel] ? R_PREFETCH : R_IDLE;
            default:    rstate_d = R_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        we    = 1'b0;
        drop  = 1'b0;
        wdata = '0;
        unique case (wstate)
            W_FILL: begin
                we    = sample_valid_in && !full[wr_sel];
                drop  = sample_valid_in &&  full[wr_sel];
                wdata = sample_in;
            end
            W_PAD:   we = !full[wr_sel];
            default: we = 1'b0;
        endcase
        wr_done = we && (wr_ptr == LAST_IDX);

        hs      = tvalid && m_axis_tready;
        last_hs = hs && tlast;
        re      = 1'b0;
        rd_addr = rd_ptr;
        if (rstate == R_PREFETCH) begin
            re      = 1'b1;
            rd_addr = '0;
        end else if (rstate == R_STREAM && hs && !tlast) begin
            // Fetch the next beat on the handshake so the output register
            // refills in the same edge: one beat per cycle while tready holds.
            re      = 1'b1;
            rd_addr = rd_ptr + AW'(1);
        end

        // Write-side set and read-side clear always target different buffers.
        full_d = full;
        if (wr_done) full_d[wr_sel] = 1'b1;
        if (last_hs) full_d[rd_sel] = 1'b0;
    end

    // Sample storage, synchronous read; rd_q only changes on a fetch so the
    // presented beat stays stable while the FFT stalls.
    always_ff @(posedge clk_in) begin
        if (we) mem[{wr_sel, wr_ptr}] <= wdata;
        if (re) rd_q <= mem[{rd_sel, rd_addr}];
    end

    // Datapath registers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            wr_sel      <= 1'b0;
            rd_ptr      <= '0;
            rd_sel      <= 1'b0;
            full        <= '0;
            overflow    <= 1'b0;
            tvalid      <= 1'b0;
            tlast       <= 1'b0;
            frame_count <= '0;
            busy        <= 1'b0;
        end else begin
            if (we) begin
                wr_ptr <= wr_done ? '0 : wr_ptr + AW'(1);
                if (wr_done) wr_sel <= ~wr_sel;
            end
            if (drop) overflow <= 1'b1;
            full <= full_d;

            if (rstate == R_PREFETCH) begin
                tvalid <= 1'b1;
                tlast  <= 1'b0;
                rd_ptr <= '0;
            end else if (rstate == R_STREAM && hs) begin
                if (tlast) begin
                    tvalid      <= 1'b0;
                    tlast       <= 1'b0;
                    rd_ptr      <= '0;
                    rd_sel      <= ~rd_sel;
                    frame_count <= frame_count + 16'd1;
                end else begin
                    rd_ptr <= rd_ptr + AW'(1);
                    tlast  <= (rd_ptr + AW'(1) == LAST_IDX);
                end
            end

            busy <= (|full_d) || (wstate_d == W_PAD) || (rstate_d != R_IDLE);
        end
    end

    assign m_axis_tdata    = tvalid ? {16'h0000, rd_q, 8'h00} : '0;
    assign m_axis_tvalid   = tvalid;
    assign m_axis_tlast    = tlast;
    assign frame_count_out = frame_count;
    assign overflow_out    = overflow;
    assign busy_out        = busy;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed testbench for fft_frame_feeder with FRAME_LEN = 8.
module tb_fft_frame_feeder;

    logic        clk_in;
    logic        rst_in_n;
    logic        sample_valid_in;
    logic [7:0]  sample_in;
    logic        flush_in;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [15:0] frame_count_out;
    logic        overflow_out;
    logic        busy_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] got_d [64];
    logic        got_l [64];
    int          nbeats;
    int          hold_viol;

    fft_frame_feeder #(.FRAME_LEN(8), .SAMPLE_W(8)) dut (
        .clk_in          (clk_in),
        .rst_in_n        (rst_in_n),
        .sample_valid_in (sample_valid_in),
        .sample_in       (sample_in),
        .flush_in        (flush_in),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .frame_count_out (frame_count_out),
        .overflow_out    (overflow_out),
        .busy_out        (busy_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset;
        rst_in_n        = 1'b0;
        sample_valid_in = 1'b0;
        sample_in       = '0;
        flush_in        = 1'b0;
        m_axis_tready   = 1'b0;
        repeat (3) tick();
        rst_in_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic send(input logic [7:0] v);
        sample_valid_in = 1'b1;
        sample_in       = v;
        tick();
        sample_valid_in = 1'b0;
    endtask

    // Records accepted beats; counts any change of a stalled beat.
    task automatic collect(input int n, input bit toggle, input int budget);
        int          cyc;
        bit          prev_stall;
        logic [31:0] prev_d;
        logic        prev_l;
        cyc = 0; prev_stall = 0; prev_d = '0; prev_l = 1'b0;
        nbeats = 0; hold_viol = 0;
        while (nbeats < n && cyc < budget) begin
            m_axis_tready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (prev_stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_d || m_axis_tlast !== prev_l))
                hold_viol++;
            if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
                got_d[nbeats] = m_axis_tdata;
                got_l[nbeats] = m_axis_tlast;
                nbeats++;
            end
            prev_stall = (m_axis_tvalid === 1'b1) && !m_axis_tready;
            prev_d     = m_axis_tdata;
            prev_l     = m_axis_tlast;
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b expected 0", m_axis_tlast); end
        checks++; if (m_axis_tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata: got %h expected 0", m_axis_tdata); end
        checks++; if (frame_count_out !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", frame_count_out); end
        checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow_out); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_out); end
    endtask

    task automatic test_basic;
        logic [31:0] exp;
        do_reset();
        m_axis_tready = 1'b1;
        for (int i = 1; i <= 8; i++) send(8'(i));
        collect(8, 1'b0, 50);
        checks++; if (nbeats !== 8) begin errors++; $display("FAIL basic_beats: got %0d expected 8", nbeats); end
        for (int i = 0; i < nbeats; i++) begin
            exp = 32'((i + 1) << 8);
            checks++; if (got_d[i] !== exp) begin errors++; $display("FAIL basic_data[%0d]: got %h expected %h", i, got_d[i], exp); end
            checks++; if (got_l[i] !== (i == 7)) begin errors++; $display("FAIL basic_tlast[%0d]: got %b expected %b", i, got_l[i], (i == 7)); end
        end
        checks++; if (frame_count_out !== 16'd1) begin errors++; $display("FAIL basic_count: got %0d expected 1", frame_count_out); end
        repeat (3) tick();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL basic_idle_tvalid: got %b expected 0", m_axis_tvalid); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b expected 0", busy_out); end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp;
        do_reset();
        for (int i = 1; i <= 8; i++) send(8'(i));
        collect(8, 1'b1, 80);
        checks++; if (nbeats !== 8) begin errors++; $display("FAIL bp_beats: got %0d expected 8", nbeats); end
        checks++; if (hold_viol !== 0) begin errors++; $display("FAIL bp_hold: got %0d changes expected 0", hold_viol); end
        for (int i = 0; i < nbeats; i++) begin
            exp = 32'((i + 1) << 8);
            checks++; if (got_d[i] !== exp) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", i, got_d[i], exp); end
            checks++; if (got_l[i] !== (i == 7)) begin errors++; $display("FAIL bp_tlast[%0d]: got %b expected %b", i, got_l[i], (i == 7)); end
        end
        checks++; if (frame_count_out !== 16'd1) begin errors++; $display("FAIL bp_count: got %0d expected 1", frame_count_out); end
    endtask

    task automatic test_flush;
        logic [31:0] exp_a [8];
        logic [31:0] exp_b [8];
        exp_a = '{32'h0000_FF00, 32'h0000_8000, 32'h0000_7F00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        exp_b = '{32'h0000_2100, 32'h0000_2200, 32'h0000_2300, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        do_reset();
        m_axis_tready = 1'b1;
        send(8'hFF); send(8'h80); send(8'h7F);
        flush_in = 1'b1; tick(); flush_in = 1'b0;
        collect(8, 1'b0, 60);
        checks++; if (nbeats !== 8) begin errors++; $display("FAIL flush_beats: got %0d expected 8", nbeats); end
        for (int i = 0; i < nbeats; i++) begin
            checks++; if (got_d[i] !== exp_a[i]) begin errors++; $display("FAIL flush_data[%0d]: got %h expected %h", i, got_d[i], exp_a[i]); end
            checks++; if (got_l[i] !== (i == 7)) begin errors++; $display("FAIL flush_tlast[%0d]: got %b expected %b", i, got_l[i], (i == 7)); end
        end
        checks++; if (frame_count_out !== 16'd1) begin errors++; $display("FAIL flush_count: got %0d expected 1", frame_count_out); end

        // Flush on an empty frame must not start padding.
        flush_in = 1'b1; tick(); flush_in = 1'b0;
        tick();
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL flush_empty_busy: got %b expected 0", busy_out); end
        repeat (12) tick();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL flush_empty_tvalid: got %b expected 0", m_axis_tvalid); end
        checks++; if (frame_count_out !== 16'd1) begin errors++; $display("FAIL flush_empty_count: got %0d expected 1", frame_count_out); end

        // Flush with a same-cycle sample; samples during padding are ignored.
        send(8'h21); send(8'h22);
        flush_in = 1'b1; send(8'h23); flush_in = 1'b0;
        send(8'h55); send(8'h55);
        collect(8, 1'b0, 60);
        checks++; if (nbeats !== 8) begin errors++; $display("FAIL flush_same_beats: got %0d expected 8", nbeats); end
        for (int i = 0; i < nbeats; i++) begin
            checks++; if (got_d[i] !== exp_b[i]) begin errors++; $display("FAIL flush_same_data[%0d]: got %h expected %h", i, got_d[i], exp_b[i]); end
        end
        checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL flush_same_overflow: got %b expected 0", overflow_out); end
        checks++; if (frame_count_out !== 16'd2) begin errors++; $display("FAIL flush_same_count: got %0d expected 2", frame_count_out); end
    endtask

    task automatic test_overflow;
        logic [31:0] exp;
        do_reset();
        for (int i = 1; i <= 16; i++) send(8'(i));
        checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b expected 0", overflow_out); end
        send(8'd17);
        checks++; if (overflow_out !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow_out); end
        checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL ovf_busy: got %b expected 1", busy_out); end
        collect(16, 1'b0, 100);
        checks++; if (nbeats !== 16) begin errors++; $display("FAIL ovf_beats: got %0d expected 16", nbeats); end
        for (int i = 0; i < nbeats; i++) begin
            exp = 32'((i + 1) << 8);
            checks++; if (got_d[i] !== exp) begin errors++; $display("FAIL ovf_data[%0d]: got %h expected %h", i, got_d[i], exp); end
            checks++; if (got_l[i] !== (i % 8 == 7)) begin errors++; $display("FAIL ovf_tlast[%0d]: got %b expected %b", i, got_l[i], (i % 8 == 7)); end
        end
        checks++; if (frame_count_out !== 16'd2) begin errors++; $display("FAIL ovf_count: got %0d expected 2", frame_count_out); end
        checks++; if (overflow_out !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow_out); end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] exp;
        do_reset();
        for (int i = 1; i <= 17; i++) send(8'(i));
        collect(4, 1'b0, 40);
        m_axis_tready = 1'b0;
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL mid_pre_tvalid: got %b expected 1", m_axis_tvalid); end
        rst_in_n = 1'b0;
        #1;
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL mid_tvalid: got %b expected 0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL mid_tlast: got %b expected 0", m_axis_tlast); end
        checks++; if (frame_count_out !== 16'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", frame_count_out); end
        checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL mid_overflow: got %b expected 0", overflow_out); end
        repeat (2) tick();
        rst_in_n = 1'b1;
        repeat (3) tick();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 8; i++) send(8'(8'h11 + i));
        collect(8, 1'b0, 50);
        checks++; if (nbeats !== 8) begin errors++; $display("FAIL mid_beats: got %0d expected 8", nbeats); end
        for (int i = 0; i < nbeats; i++) begin
            exp = 32'((8'h11 + i) << 8);
            checks++; if (got_d[i] !== exp) begin errors++; $display("FAIL mid_data[%0d]: got %h expected %h", i, got_d[i], exp); end
        end
        checks++; if (frame_count_out !== 16'd1) begin errors++; $display("FAIL mid_post_count: got %0d expected 1", frame_count_out); end
        repeat (4) tick();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL mid_no_stale: got %b expected 0", m_axis_tvalid); end
    endtask

    // Read side spends FRAME_LEN handshakes plus a prefetch cycle per frame,
    // so the feed runs at half rate to stay clear of overflow.
    task automatic test_back_to_back;
        logic [31:0] exp;
        do_reset();
        fork
            begin
                for (int i = 1; i <= 32; i++) begin
                    sample_valid_in = 1'b1;
                    sample_in       = 8'(i);
                    tick();
                    sample_valid_in = 1'b0;
                    tick();
                end
            end
            collect(32, 1'b0, 300);
        join
        checks++; if (nbeats !== 32) begin errors++; $display("FAIL b2b_beats: got %0d expected 32", nbeats); end
        for (int i = 0; i < nbeats; i++) begin
            exp = 32'((i + 1) << 8);
            checks++; if (got_d[i] !== exp) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, got_d[i], exp); end
            checks++; if (got_l[i] !== (i % 8 == 7)) begin errors++; $display("FAIL b2b_tlast[%0d]: got %b expected %b", i, got_l[i], (i % 8 == 7)); end
        end
        checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b expected 0", overflow_out); end
        checks++; if (frame_count_out !== 16'd4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", frame_count_out); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_flush();
        test_overflow();
        test_reset_midframe();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
